// File: rtl/lpad_check_ctrl.sv
// Forward-edge CFI landing-pad controller: arms on a committed indirect jump, demands an LPAD
// as the next committed instruction and sequences the shared ALU label compare.
module lpad_check_ctrl #(
    parameter int LABEL_W = 20,
    parameter int XLEN    = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic               ijump_valid_i,
    input  logic [LABEL_W-1:0] ijump_label_i,
    input  logic               commit_valid_i,
    input  logic               commit_is_lpad_i,
    input  logic [LABEL_W-1:0] commit_lpad_label_i,
    output logic               commit_ready_o,
    output logic               alu_req_valid_o,
    input  logic               alu_req_ready_i,
    output logic [XLEN-1:0]    alu_operand_a_o,
    output logic [XLEN-1:0]    alu_operand_b_o,
    input  logic               alu_resp_valid_i,
    input  logic               alu_branch_res_i,
    output logic               fault_o,
    output logic [1:0]         fault_cause_o,
    output logic               elp_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXPECT = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISSING  = 2'd1;
    localparam logic [1:0] CAUSE_MISMATCH = 2'd2;

    state_t             state_r, state_s;
    logic [LABEL_W-1:0] exp_label_r, exp_label_s;
    logic [LABEL_W-1:0] lpad_label_r, lpad_label_s;
    logic               abort_r, abort_s;
    logic               fault_r, fault_s;
    logic [1:0]         cause_r, cause_s;
    logic               commit_ready_s;
    logic               kill_s;

    // Next-state, label capture, fault detection and commit back-pressure
    always_comb begin
        kill_s         = flush_i | ~en_i;
        state_s        = state_r;
        exp_label_s    = exp_label_r;
        lpad_label_s   = lpad_label_r;
        abort_s        = abort_r;
        fault_s        = 1'b0;
        cause_s        = CAUSE_NONE;
        commit_ready_s = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (!kill_s && ijump_valid_i) begin
                    state_s     = ST_EXPECT;
                    exp_label_s = ijump_label_i;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXPECT: begin
                if (kill_s) begin
                    state_s = ST_IDLE;
                end else if (commit_valid_i) begin
                    if (!commit_is_lpad_i) begin
                        // a fault beats a jump committing in the same cycle
                        state_s = ST_IDLE;
                        fault_s = 1'b1;
                        cause_s = CAUSE_MISSING;
                    end else if (commit_lpad_label_i == {LABEL_W{1'b0}}) begin
                        if (ijump_valid_i) begin
                            state_s     = ST_EXPECT;
                            exp_label_s = ijump_label_i;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        commit_ready_s = 1'b0;
                        lpad_label_s   = commit_lpad_label_i;
                        abort_s        = 1'b0;
                        state_s        = ST_REQ;
                    end
                end else begin
                    state_s = ST_EXPECT;
                end
            end
            ST_REQ: begin
                commit_ready_s = 1'b0;
                if (kill_s) begin
                    abort_s = 1'b1;
                end else begin
                    abort_s = abort_r;
                end
                if (alu_req_ready_i) begin
                    state_s = (abort_r || kill_s) ? ST_DRAIN : ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                commit_ready_s = alu_resp_valid_i;
                if (alu_resp_valid_i) begin
                    state_s = ST_IDLE;
                    if (!alu_branch_res_i && !kill_s) begin
                        fault_s = 1'b1;
                        cause_s = CAUSE_MISMATCH;
                    end else begin
                        fault_s = 1'b0;
                    end
                end else if (kill_s) begin
                    state_s = ST_DRAIN;
                    abort_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                commit_ready_s = 1'b0;
                if (alu_resp_valid_i) begin
                    state_s = ST_IDLE;
                    abort_s = 1'b0;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                abort_s = 1'b0;
            end
        endcase
    end

    // State, captured labels and the one-cycle fault pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            exp_label_r  <= {LABEL_W{1'b0}};
            lpad_label_r <= {LABEL_W{1'b0}};
            abort_r      <= 1'b0;
            fault_r      <= 1'b0;
            cause_r      <= CAUSE_NONE;
        end else begin
            state_r      <= state_s;
            exp_label_r  <= exp_label_s;
            lpad_label_r <= lpad_label_s;
            abort_r      <= abort_s;
            fault_r      <= fault_s;
            cause_r      <= cause_s;
        end
    end

    assign commit_ready_o  = commit_ready_s;
    assign alu_req_valid_o = (state_r == ST_REQ);
    assign elp_o           = (state_r == ST_EXPECT);
    assign alu_operand_a_o = {{(XLEN-LABEL_W){1'b0}}, lpad_label_r};
    assign alu_operand_b_o = {{(XLEN-LABEL_W){1'b0}}, exp_label_r};
    assign fault_o         = fault_r;
    assign fault_cause_o   = cause_r;

endmodule

// File: tb/tb_lpad_check_ctrl.sv
// Bench for lpad_check_ctrl: a directed cycle table for the documented scenarios, then
// randomized traffic against a transaction-level reference model with a bench-side ALU.
module tb_lpad_check_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en, flush, ijump_valid, commit_valid, commit_is_lpad;
    logic [19:0] ijump_label, commit_lpad_label;
    logic        commit_ready, alu_req_valid, alu_req_ready;
    logic [63:0] alu_operand_a, alu_operand_b;
    logic        alu_resp_valid, alu_branch_res, fault, elp;
    logic [1:0]  fault_cause;

    int n_vec = 0;
    int n_err = 0;

    lpad_check_ctrl #(.LABEL_W(20), .XLEN(64)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
        .ijump_valid_i(ijump_valid), .ijump_label_i(ijump_label),
        .commit_valid_i(commit_valid), .commit_is_lpad_i(commit_is_lpad),
        .commit_lpad_label_i(commit_lpad_label), .commit_ready_o(commit_ready),
        .alu_req_valid_o(alu_req_valid), .alu_req_ready_i(alu_req_ready),
        .alu_operand_a_o(alu_operand_a), .alu_operand_b_o(alu_operand_b),
        .alu_resp_valid_i(alu_resp_valid), .alu_branch_res_i(alu_branch_res),
        .fault_o(fault), .fault_cause_o(fault_cause), .elp_o(elp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rs, en, fl, ijv;
        logic [19:0] ijl;
        logic        cv, il;
        logic [19:0] cl;
        logic        arr, rv, rb;
        logic        er, eq, ee, ef;
        logic [1:0]  ec;
        logic        co;
        logic [19:0] ea, eb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int rs, en_v, fl, ijv, ijl, cv, il, cl, arr, rv, rb,
                       input int er, eq, ee, ef, ec, co, ea, eb);
        vec_t v;
        v.rs = (rs != 0); v.en = (en_v != 0); v.fl = (fl != 0); v.ijv = (ijv != 0);
        v.ijl = 20'(ijl); v.cv = (cv != 0); v.il = (il != 0); v.cl = 20'(cl);
        v.arr = (arr != 0); v.rv = (rv != 0); v.rb = (rb != 0);
        v.er = (er != 0); v.eq = (eq != 0); v.ee = (ee != 0); v.ef = (ef != 0);
        v.ec = 2'(ec); v.co = (co != 0); v.ea = 20'(ea); v.eb = 20'(eb);
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rs, en_v, fl, ijv, input logic [19:0] ijl,
                         input logic cv, il, input logic [19:0] cl,
                         input logic arr, rv, rb);
        rst = rs; en = en_v; flush = fl; ijump_valid = ijv; ijump_label = ijl;
        commit_valid = cv; commit_is_lpad = il; commit_lpad_label = cl;
        alu_req_ready = arr; alu_resp_valid = rv; alu_branch_res = rb;
    endtask

    // reference model state: armed/expected label, outstanding request or response
    logic        m_armed, m_req, m_wait, m_cancel, m_fault;
    logic [19:0] m_want, m_a;
    logic [1:0]  m_cause;
    logic        alu_busy, alu_res;
    int          alu_cnt;

    function automatic logic [19:0] pick_label(input logic [19:0] want);
        logic [19:0] r;
        case ($urandom_range(0, 3))
            0:       r = 20'h0;
            1, 2:    r = want;
            default: r = 20'($urandom);
        endcase
        return r;
    endfunction

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);

        // rs en fl ijv ijl  cv il cl  arr rv rb | ready req elp fault cause | co a b
        add(1,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 1,0,0);
        // matching label through the ALU
        add(0,1,0,1,'hABC,  0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      1,1,'hABC,  0,0,0,  0,0,1,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      1,0,0,  0,1,0,0,0, 1,'hABC,'hABC);
        add(0,1,0,0,0,      0,0,0,      0,1,1,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        // label mismatch: fault cause 2, lpad retires on response
        add(0,1,0,1,'hABC,  0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      1,1,'h123,  0,0,0,  0,0,1,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  0,1,0,0,0, 1,'h123,'hABC);
        add(0,1,0,0,0,      0,0,0,      1,0,0,  0,1,0,0,0, 1,'h123,'hABC);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  0,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,1,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,1,2, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        // missing LPAD: fault cause 1
        add(0,1,0,1,'h055,  0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      1,0,0,      0,0,0,  1,0,1,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,1,1, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        // wildcard label 0: no request
        add(0,1,0,1,'h777,  0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      1,1,0,      0,0,0,  1,0,1,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        // ready held low, flush while requesting, drained response ignored
        add(0,1,0,1,'h0AA,  0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      1,1,'h0AA,  0,0,0,  0,0,1,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  0,1,0,0,0, 1,'h0AA,'h0AA);
        add(0,1,1,0,0,      0,0,0,      0,0,0,  0,1,0,0,0, 1,'h0AA,'h0AA);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  0,1,0,0,0, 1,'h0AA,'h0AA);
        add(0,1,0,0,0,      0,0,0,      1,0,0,  0,1,0,0,0, 1,'h0AA,'h0AA);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  0,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,1,0,  0,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        // enforcement disabled: jump ignored
        add(0,0,0,1,'h321,  0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        // passing wildcard plus a new jump re-arms with the new label
        add(0,1,0,1,'h100,  0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,1,'h200,  1,1,0,      0,0,0,  1,0,1,0,0, 0,0,0);
        add(0,1,0,0,0,      1,1,'h200,  0,0,0,  0,0,1,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      1,0,0,  0,1,0,0,0, 1,'h200,'h200);
        add(0,1,0,0,0,      0,0,0,      0,1,1,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        // reset while waiting; the late response is ignored
        add(0,1,0,1,'h0F0,  0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      1,1,'h0F1,  0,0,0,  0,0,1,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      1,0,0,  0,1,0,0,0, 1,'h0F1,'h0F0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  0,0,0,0,0, 0,0,0);
        add(1,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 1,0,0);
        add(0,1,0,0,0,      0,0,0,      0,1,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        // flush beats a jump; flushed EXPECT raises no fault
        add(0,1,1,1,'h333,  0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,0,1,'h444,  0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);
        add(0,1,1,0,0,      1,0,0,      0,0,0,  1,0,1,0,0, 0,0,0);
        add(0,1,0,0,0,      0,0,0,      0,0,0,  1,0,0,0,0, 0,0,0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rs, tbl[i].en, tbl[i].fl, tbl[i].ijv, tbl[i].ijl, tbl[i].cv,
                  tbl[i].il, tbl[i].cl, tbl[i].arr, tbl[i].rv, tbl[i].rb);
            #1;
            chk($sformatf("row%0d commit_ready", i), 64'(commit_ready), 64'(tbl[i].er));
            chk($sformatf("row%0d alu_req_valid", i), 64'(alu_req_valid), 64'(tbl[i].eq));
            chk($sformatf("row%0d elp", i), 64'(elp), 64'(tbl[i].ee));
            chk($sformatf("row%0d fault", i), 64'(fault), 64'(tbl[i].ef));
            chk($sformatf("row%0d fault_cause", i), 64'(fault_cause), 64'(tbl[i].ec));
            if (tbl[i].co) begin
                chk($sformatf("row%0d operand_a", i), alu_operand_a, 64'(tbl[i].ea));
                chk($sformatf("row%0d operand_b", i), alu_operand_b, 64'(tbl[i].eb));
            end
        end

        // randomized traffic against the reference model
        m_armed = 1'b0; m_req = 1'b0; m_wait = 1'b0; m_cancel = 1'b0; m_fault = 1'b0;
        m_want = 20'h0; m_a = 20'h0; m_cause = 2'd0;
        alu_busy = 1'b0; alu_res = 1'b0; alu_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic rs_v, en_v, fl_v, ijv_v, cv_v, il_v, arr_v, rv_v, rb_v, kill, exp_ready;
            logic [19:0] ijl_v, cl_v;
            logic nf;
            logic [1:0] nc;
            @(negedge clk);
            rs_v  = ($urandom_range(0, 249) == 0);
            en_v  = ($urandom_range(0, 19) != 0);
            fl_v  = ($urandom_range(0, 11) == 0);
            cv_v  = $urandom_range(0, 1) == 1;
            il_v  = ($urandom_range(0, 3) != 0);
            cl_v  = pick_label(m_want);
            arr_v = $urandom_range(0, 1) == 1;
            rv_v  = 1'b0;
            rb_v  = 1'b0;
            if (alu_busy) begin
                if (alu_cnt == 0) begin
                    rv_v = 1'b1;
                    rb_v = alu_res;
                end else begin
                    alu_cnt--;
                end
            end
            ijv_v = !m_req && !m_wait &&
                    (!m_armed || (cv_v && !(il_v && cl_v != 20'h0))) &&
                    ($urandom_range(0, 2) == 0);
            ijl_v = pick_label(20'hABC);
            drive(rs_v, en_v, fl_v, ijv_v, ijl_v, cv_v, il_v, cl_v, arr_v, rv_v, rb_v);
            #1;
            kill = fl_v || !en_v;
            if (rs_v) begin
                exp_ready = 1'b1;
            end else if (m_req) begin
                exp_ready = 1'b0;
            end else if (m_wait) begin
                exp_ready = m_cancel ? 1'b0 : rv_v;
            end else begin
                exp_ready = !(m_armed && cv_v && !kill && il_v && cl_v != 20'h0);
            end
            chk("rnd commit_ready", 64'(commit_ready), 64'(exp_ready));
            chk("rnd alu_req_valid", 64'(alu_req_valid), 64'(m_req && !rs_v));
            chk("rnd elp", 64'(elp), 64'(m_armed && !rs_v));
            chk("rnd fault", 64'(fault), 64'(m_fault && !rs_v));
            chk("rnd fault_cause", 64'(fault_cause), rs_v ? 64'd0 : 64'(m_cause));
            if (m_req && !rs_v) begin
                chk("rnd operand_a", alu_operand_a, 64'(m_a));
                chk("rnd operand_b", alu_operand_b, 64'(m_want));
            end

            nf = 1'b0;
            nc = 2'd0;
            if (rs_v) begin
                m_armed = 1'b0; m_req = 1'b0; m_wait = 1'b0; m_cancel = 1'b0;
                alu_busy = 1'b0;
            end else if (m_req) begin
                if (kill) m_cancel = 1'b1;
                if (arr_v) begin
                    m_req    = 1'b0;
                    m_wait   = 1'b1;
                    alu_busy = 1'b1;
                    alu_cnt  = $urandom_range(0, 3);
                    alu_res  = (m_a == m_want);
                end
            end else if (m_wait) begin
                if (rv_v) begin
                    m_wait   = 1'b0;
                    alu_busy = 1'b0;
                    if (!m_cancel && !kill && !rb_v) begin
                        nf = 1'b1;
                        nc = 2'd2;
                    end
                    m_cancel = 1'b0;
                end else if (kill) begin
                    m_cancel = 1'b1;
                end
            end else if (m_armed) begin
                if (kill) begin
                    m_armed = 1'b0;
                end else if (cv_v) begin
                    if (!il_v) begin
                        m_armed = 1'b0;
                        nf = 1'b1;
                        nc = 2'd1;
                    end else if (cl_v == 20'h0) begin
                        m_armed = ijv_v;
                        if (ijv_v) m_want = ijl_v;
                    end else begin
                        m_armed  = 1'b0;
                        m_req    = 1'b1;
                        m_cancel = 1'b0;
                        m_a      = cl_v;
                    end
                end
            end else if (ijv_v && !kill) begin
                m_armed = 1'b1;
                m_want  = ijl_v;
            end
            m_fault = nf;
            m_cause = nc;
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
